// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant hold and forced preemption.
// Registered grant index/enable feed a downstream 2-to-4 enable decoder.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [1:0] grant_idx,
    output logic       grant_en,
    output logic       preempt
);

    typedef enum logic {StIdle, StGrant} state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;
    logic       rel_drop, rel_max;

    // First set bit of r in circular order starting at base.
    function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] idx;
        pick = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        rel_drop  = 1'b0;
        rel_max   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    state_d = StGrant;
                    idx_d   = pick(ptr_q, req);
                    hold_d  = 8'd0;
                end
            end
            StGrant: begin
                rel_drop = !req[idx_q];
                rel_max  = req[idx_q] && (hold_q == HoldLast);
                if (!rel_drop && !rel_max) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    ptr_d     = idx_q + 2'd1;
                    preempt_d = rel_max;
                    // On a drop req[g] is already 0, so req is the re-arbitration set as-is;
                    // on a max release g stays eligible and wins only if nobody else asks.
                    if (req != 4'b0000) begin
                        idx_d  = pick(idx_q + 2'd1, req);
                        hold_d = 8'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant_idx = idx_q;
    assign grant_en  = (state_q == StGrant);
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus random requests, checked against a
// cycle-level behavioural model of the round-robin rules.
module tb_rr_arbiter4;

    localparam int MH = 4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [1:0] grant_idx;
    logic       grant_en;
    logic       preempt;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state.
    int m_ptr;
    int m_idx;
    int m_held;   // cycles the current grant has been visible, 1-based
    bit m_en;
    bit m_pre;

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .grant_idx(grant_idx),
        .grant_en (grant_en),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_from(input int base, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return base;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_idx  = 0;
        m_held = 0;
        m_en   = 1'b0;
        m_pre  = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int g;
        m_pre = 1'b0;
        if (!m_en) begin
            if (r != 4'b0000) begin
                m_en   = 1'b1;
                m_idx  = first_from(m_ptr, r);
                m_held = 1;
            end
        end else begin
            g = m_idx;
            if (r[g] && m_held < MH) begin
                m_held++;
            end else begin
                m_pre = r[g];
                m_ptr = (g + 1) % 4;
                if (r != 4'b0000) begin
                    m_idx  = first_from(m_ptr, r);
                    m_held = 1;
                end else begin
                    m_en = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant_en"}, {3'b000, grant_en}, {3'b000, m_en});
        check({tag, ".preempt"}, {3'b000, preempt}, {3'b000, m_pre});
        if (m_en) check({tag, ".grant_idx"}, {2'b00, grant_idx}, 4'(m_idx));
    endtask

    // Drive req before the edge, advance the model at the edge, sample on the falling edge.
    task automatic step(input string tag, input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_all(tag);
    endtask

    // Async reset between edges: outputs must clear with no clock.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_en"}, {3'b000, grant_en}, 4'd0);
        check({tag, ".rst_pre"}, {3'b000, preempt}, 4'd0);
        check({tag, ".rst_idx"}, {2'b00, grant_idx}, 4'd0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        reset_n = 1'b0;
        req     = 4'b1111;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.grant_en", {3'b000, grant_en}, 4'd0);
        check("reset.preempt", {3'b000, preempt}, 4'd0);
        check("reset.grant_idx", {2'b00, grant_idx}, 4'd0);
        reset_n = 1'b1;

        // Full contention: 0,0,0,0,1,1,1,1,... with preempt on each handover.
        for (int i = 0; i < 18; i++) step("contend", 4'b1111);
        step("to_idle", 4'b0000);

        // Single requester, then drop, then wrap from ptr=3.
        for (int i = 0; i < 3; i++) step("single", 4'b0100);
        step("single_drop", 4'b0000);
        step("wrap", 4'b0110);
        check("wrap.idx_is_1", {2'b00, grant_idx}, 4'd1);
        step("wrap_drop", 4'b0000);

        // Sole requester is preempted and re-granted every MH cycles.
        for (int i = 0; i < 12; i++) step("sole", 4'b0001);

        // Back-to-back handover on drop with no idle bubble.
        step("b2b_a", 4'b1010);
        step("b2b_b", 4'b1010);
        step("b2b_drop", 4'b1000);
        check("b2b.idx_is_3", {2'b00, grant_idx}, 4'd3);

        // Reset mid-grant, restart search from ptr=0.
        pulse_reset("midgrant");
        step("after_rst", 4'b1000);
        check("after_rst.idx_is_3", {2'b00, grant_idx}, 4'd3);

        // Random requests, mostly held, occasional idle and reset.
        r = 4'b0000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 19) == 0) r = 4'b0000;
            step("rand", r);
            if ($urandom_range(0, 59) == 0) pulse_reset("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
